// File: rtl/pwm_decode_pkg.sv
// Shared constants, state encoding and width helpers for the PWM decoder.
package pwm_decode_pkg;

  // Default geometry of the decoder.
  localparam int unsigned NumBitsDef   = 11;
  localparam int unsigned RangeHDef    = 28;
  localparam int unsigned MinPeriodDef = 16;

  // Width of the decoded output word.
  localparam int unsigned DataW = 48;

  // Number of cycles data_ready is held high after each update.
  localparam int unsigned StretchLen = 4;

  // Counter / difference width for a given resolution (two guard bits).
  function automatic int unsigned cnt_width(int unsigned num_bits);
    return num_bits + 2;
  endfunction

  // Cycles without a valid edge before the input is declared stuck.
  function automatic int unsigned timeout_cycles(int unsigned num_bits);
    return (32'd1 << (num_bits + 1)) - 32'd1;
  endfunction

  localparam int unsigned CntWDef    = cnt_width(NumBitsDef);
  localparam int unsigned TimeoutDef = timeout_cycles(NumBitsDef);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer, history flop and edge detector for the PWM input.
module edge_sync (
  input  logic clk_pwm,
  input  logic nreset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       hist_q, hist_d;
  logic [2:0] warm_q, warm_d;

  // Shift the input through the chain; warm fills with ones after reset.
  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    warm_d  = {warm_q[1:0], 1'b1};
  end

  // Synchronizer, history and warm-up registers.
  always_ff @(posedge clk_pwm or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      warm_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      warm_q  <= warm_d;
    end
  end

  // hist_q holds a genuine post-reset sample only once warm_q[2] is set; before that an
  // input already high at reset release would masquerade as a rising edge.
  always_comb begin
    level = sync2_q;
    rise  = warm_q[2] & sync2_q & ~hist_q;
    fall  = warm_q[2] & ~sync2_q & hist_q;
  end

endmodule

// File: rtl/pwm_decode.sv
// Decodes an offset-binary PWM stream into a signed, left-aligned sample word.
// High and low phase lengths are counted; their difference is the sample.
module pwm_decode
  import pwm_decode_pkg::*;
#(
  parameter int unsigned RANGE_H    = RangeHDef,
  parameter int unsigned NUM_BITS   = NumBitsDef,
  parameter int unsigned MIN_PERIOD = MinPeriodDef
) (
  input  logic             clk_pwm,
  input  logic             nreset,
  input  logic             pwm_in,
  output logic [DataW-1:0] data,
  output logic             data_ready,
  output logic             timeout
);

  localparam int unsigned CntW    = cnt_width(NUM_BITS);
  localparam int unsigned SumW    = CntW + 1;
  localparam int unsigned Timeout = timeout_cycles(NUM_BITS);
  // Bit position of the LSB of the difference field inside data.
  localparam int unsigned Lsb     = RANGE_H - NUM_BITS - 1;

  // nreset is asserted asynchronously; its release is expected synchronous to clk_pwm.

  logic level, rise, fall;

  edge_sync u_edge_sync (
    .clk_pwm (clk_pwm),
    .nreset  (nreset),
    .pwm_in  (pwm_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  state_e                 state_q, state_d;
  logic [CntW-1:0]        hi_cnt_q, hi_cnt_d;
  logic [CntW-1:0]        lo_cnt_q, lo_cnt_d;
  logic [CntW-1:0]        idle_cnt_q, idle_cnt_d;
  logic                   smp_vld_q, smp_vld_d;
  logic signed [CntW-1:0] smp_diff_q, smp_diff_d;
  logic                   timeout_q, timeout_d;

  logic [DataW-1:0]       data_q, data_d;
  logic [1:0]             rdy_cnt_q, rdy_cnt_d;
  logic                   data_ready_q, data_ready_d;

  logic [SumW-1:0]        period_sum;
  logic                   tmo_hit;
  logic                   long_enough;
  logic [CntW-1:0]        sat_pos;
  logic [CntW-1:0]        sat_diff;

  // Period length so far, its limits, and the saturated sample for a stuck input.
  always_comb begin
    period_sum  = SumW'(hi_cnt_q) + SumW'(lo_cnt_q);
    tmo_hit     = period_sum >= SumW'(Timeout);
    long_enough = period_sum >= SumW'(MIN_PERIOD);
    sat_pos     = CntW'(Timeout);
    sat_diff    = level ? sat_pos : (~sat_pos + CntW'(1));
  end

  // FSM next state: phase counting, sample generation, glitch rejection and timeout.
  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    lo_cnt_d   = lo_cnt_q;
    idle_cnt_d = idle_cnt_q;
    smp_vld_d  = 1'b0;
    smp_diff_d = smp_diff_q;
    timeout_d  = timeout_q;

    if (rise) begin
      timeout_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        hi_cnt_d = '0;
        lo_cnt_d = '0;
        if (rise) begin
          // First partial period: start measuring, never emit from here.
          state_d    = StHigh;
          hi_cnt_d   = CntW'(1);
          idle_cnt_d = '0;
        end else if (fall) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= CntW'(Timeout - 1)) begin
          // Input still stuck: repeat the saturated sample.
          idle_cnt_d = '0;
          smp_vld_d  = 1'b1;
          smp_diff_d = sat_diff;
          timeout_d  = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CntW'(1);
        end
      end

      StHigh: begin
        if (fall) begin
          state_d  = StLow;
          lo_cnt_d = CntW'(1);
        end else if (tmo_hit) begin
          state_d    = StIdle;
          hi_cnt_d   = '0;
          lo_cnt_d   = '0;
          idle_cnt_d = '0;
          smp_vld_d  = 1'b1;
          smp_diff_d = sat_diff;
          timeout_d  = 1'b1;
        end else begin
          hi_cnt_d = hi_cnt_q + CntW'(1);
        end
      end

      StLow: begin
        if (rise) begin
          // A too-short period is dropped and measurement restarts from this edge.
          state_d  = StHigh;
          hi_cnt_d = CntW'(1);
          lo_cnt_d = '0;
          if (long_enough) begin
            smp_vld_d  = 1'b1;
            smp_diff_d = hi_cnt_q - lo_cnt_q;
          end
        end else if (tmo_hit) begin
          state_d    = StIdle;
          hi_cnt_d   = '0;
          lo_cnt_d   = '0;
          idle_cnt_d = '0;
          smp_vld_d  = 1'b1;
          smp_diff_d = sat_diff;
          timeout_d  = 1'b1;
        end else begin
          lo_cnt_d = lo_cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d    = StIdle;
        hi_cnt_d   = '0;
        lo_cnt_d   = '0;
        idle_cnt_d = '0;
      end
    endcase
  end

  // FSM, counters and staged sample registers.
  always_ff @(posedge clk_pwm or negedge nreset) begin
    if (!nreset) begin
      state_q    <= StIdle;
      hi_cnt_q   <= '0;
      lo_cnt_q   <= '0;
      idle_cnt_q <= '0;
      smp_vld_q  <= 1'b0;
      smp_diff_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_cnt_q   <= hi_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      smp_vld_q  <= smp_vld_d;
      smp_diff_q <= smp_diff_d;
      timeout_q  <= timeout_d;
    end
  end

  // Output stage: place the difference field, sign-extend above it, and stretch the
  // strobe so slow consumers can see it. A new sample restarts the stretch.
  always_comb begin
    data_d       = data_q;
    rdy_cnt_d    = rdy_cnt_q;
    data_ready_d = 1'b0;
    if (smp_vld_q) begin
      data_d       = DataW'(smp_diff_q) << Lsb;
      rdy_cnt_d    = 2'(StretchLen - 1);
      data_ready_d = 1'b1;
    end else if (rdy_cnt_q != 2'd0) begin
      rdy_cnt_d    = rdy_cnt_q - 2'd1;
      data_ready_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk_pwm or negedge nreset) begin
    if (!nreset) begin
      data_q       <= '0;
      rdy_cnt_q    <= '0;
      data_ready_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      rdy_cnt_q    <= rdy_cnt_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign data       = data_q;
  assign data_ready = data_ready_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_decode.sv
// Self-checking bench for pwm_decode: table-driven periods plus directed sequences,
// with a scoreboard of expected samples keyed by the cycle they must appear.
module tb_pwm_decode;

  logic        clk_pwm = 1'b0;
  logic        nreset  = 1'b0;
  logic        pwm_in  = 1'b0;
  logic [47:0] data;
  logic        data_ready;
  logic        timeout;

  pwm_decode #(
    .RANGE_H    (28),
    .NUM_BITS   (11),
    .MIN_PERIOD (16)
  ) dut (
    .clk_pwm    (clk_pwm),
    .nreset     (nreset),
    .pwm_in     (pwm_in),
    .data       (data),
    .data_ready (data_ready),
    .timeout    (timeout)
  );

  always #5 clk_pwm = ~clk_pwm;

  int cyc = 0;
  always @(posedge clk_pwm) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int rel_cyc = 0;

  typedef struct {
    int          due;
    logic [47:0] dat;
    logic        tmo;
  } exp_t;

  typedef struct {
    int hi;
    int lo;
    bit smp;
    int diff;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  function automatic logic [47:0] mk(input int d);
    logic signed [47:0] v;
    v = 48'(d);
    return v <<< 16;
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_pwm);
  endtask

  task automatic push(input int due, input int diff, input logic tmo);
    exp_t e;
    e.due = due;
    e.dat = mk(diff);
    e.tmo = tmo;
    sb_q.push_back(e);
  endtask

  // Starts with pwm_in already high; ends on the rise that closes the period.
  task automatic period(input int hi, input int lo, input bit smp, input int diff);
    tick(hi);
    pwm_in = 1'b0;
    tick(lo);
    pwm_in = 1'b1;
    if (smp) push(cyc + 4, diff, 1'b0);
  endtask

  task automatic pulse_reset();
    nreset = 1'b0;
    tick(3);
    chk("rst_data", data, 48'd0);
    chk("rst_ready", 48'(data_ready), 48'd0);
    chk("rst_timeout", 48'(timeout), 48'd0);
    nreset  = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic do_reset(input logic lvl);
    tick(1);
    pwm_in = lvl;
    pulse_reset();
  endtask

  task automatic drain(input string name);
    tick(12);
    chk(name, 48'(sb_q.size()), 48'd0);
    sb_q.delete();
  endtask

  // Monitor: strobe rise pops the scoreboard; width and data stability checked throughout.
  initial begin
    exp_t        e;
    logic        rdy_prev;
    logic        nrst_prev;
    logic [47:0] data_prev;
    int          width;
    rdy_prev  = 1'b0;
    nrst_prev = 1'b0;
    data_prev = '0;
    width     = 0;
    forever begin
      @(negedge clk_pwm);
      if (nreset && nrst_prev) begin
        if (data_ready && !rdy_prev) begin
          chk("strobe_expected", 48'(sb_q.size() != 0), 48'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sample_data", data, e.dat);
            chk("sample_cycle", 48'(cyc), 48'(e.due));
            chk("sample_timeout", 48'(timeout), 48'(e.tmo));
          end
        end else begin
          chk("data_stable", data, data_prev);
        end
        if (!data_ready && rdy_prev) chk("ready_width", 48'(width), 48'd4);
      end
      width     = data_ready ? width + 1 : 0;
      rdy_prev  = data_ready;
      nrst_prev = nreset;
      data_prev = data;
    end
  end

  initial begin
    vecs[0]  = '{300, 100, 1'b1, 200};
    vecs[1]  = '{300, 100, 1'b1, 200};
    vecs[2]  = '{100, 300, 1'b1, -200};
    vecs[3]  = '{100, 300, 1'b1, -200};
    vecs[4]  = '{1024, 1024, 1'b1, 0};
    vecs[5]  = '{1024, 1024, 1'b1, 0};
    vecs[6]  = '{8, 8, 1'b1, 0};
    vecs[7]  = '{7, 8, 1'b0, 0};
    vecs[8]  = '{10, 6, 1'b1, 4};
    vecs[9]  = '{1, 40, 1'b1, -39};
    vecs[10] = '{40, 1, 1'b1, 39};
    vecs[11] = '{3000, 1000, 1'b1, 2000};

    // Table of periods; the first rise after reset only starts measurement.
    do_reset(1'b0);
    tick(6);
    pwm_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      period(vecs[i].hi, vecs[i].lo, vecs[i].smp, vecs[i].diff);
      if (i == 5) chk("timeout_low_50pct", 48'(timeout), 48'd0);
    end
    tick(10);
    drain("table_drained");

    // Held high from reset: saturated positive samples every 4095 cycles.
    do_reset(1'b1);
    push(rel_cyc + 4096, 4095, 1'b1);
    push(rel_cyc + 8191, 4095, 1'b1);
    tick(4094);
    chk("no_timeout_early", 48'(timeout), 48'd0);
    tick(1);
    chk("timeout_set_high", 48'(timeout), 48'd1);
    tick(4104);
    drain("held_high_drained");

    // Held low from reset, then a rising edge clears timeout.
    do_reset(1'b0);
    push(rel_cyc + 4096, -4095, 1'b1);
    tick(4096);
    drain("held_low_drained");
    pwm_in = 1'b1;
    tick(2);
    chk("timeout_before_clear", 48'(timeout), 48'd1);
    tick(1);
    chk("timeout_cleared", 48'(timeout), 48'd0);
    tick(20);
    drain("after_clear_drained");

    // Glitch within 16 cycles of a valid rise is rejected; then stuck high times out.
    do_reset(1'b0);
    tick(6);
    pwm_in = 1'b1;
    period(300, 100, 1'b1, 200);
    period(4, 6, 1'b0, 0);
    period(5, 200, 1'b1, -195);
    push(cyc + 4099, 4095, 1'b1);
    tick(4110);
    drain("glitch_drained");

    // Reset in the middle of a high phase discards the partial measurement.
    do_reset(1'b0);
    tick(6);
    pwm_in = 1'b1;
    period(300, 100, 1'b1, 200);
    tick(150);
    pulse_reset();
    tick(150);
    pwm_in = 1'b0;
    tick(100);
    pwm_in = 1'b1;
    period(300, 100, 1'b1, 200);
    tick(10);
    drain("midreset_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_decode.md
PWM_DECODE -- requirements
Module: pwm_decode

Interface
REQ-001 The module SHALL have parameter RANGE_H, default 28, giving the MSB position of the sample field within data.
REQ-002 The module SHALL have parameter NUM_BITS, default 11, giving the nominal PWM resolution. The decoded difference field is NUM_BITS+2 bits, signed.
REQ-003 The module SHALL have parameter MIN_PERIOD, default 16, giving the minimum accepted PWM period in clk_pwm cycles.
REQ-004 The module SHALL have port clk_pwm, input, 1 bit: the single clock for all logic.
REQ-005 The module SHALL have port nreset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port pwm_in, input, 1 bit: asynchronous offset-binary PWM stream, where 50% duty means zero.
REQ-007 The module SHALL have port data, output, 48 bits: signed decoded sample.
REQ-008 The module SHALL have port data_ready, output, 1 bit: stretched strobe marking a new sample.
REQ-009 The module SHALL have port timeout, output, 1 bit: asserted while no valid PWM edge has been seen for TIMEOUT cycles.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer plus one history flop. A rising or falling edge SHALL be detected on the 3rd clk_pwm edge after the input transition.
REQ-011 The FSM SHALL have exactly three states, IDLE, HIGH and LOW, with these transitions:
- IDLE to HIGH on a rising edge.
- HIGH to LOW on a falling edge.
- LOW to HIGH on a rising edge.
- HIGH or LOW to IDLE on timeout.
REQ-012 Counters hi_cnt and lo_cnt SHALL each be NUM_BITS+2 bits unsigned. hi_cnt SHALL increment in HIGH and lo_cnt SHALL increment in LOW. Both SHALL be 0 in IDLE.
REQ-013 On entering HIGH from IDLE or LOW, both counters SHALL clear; hi_cnt SHALL count the entry cycle as 1.
REQ-014 On a LOW-to-HIGH rising edge where hi_cnt+lo_cnt >= MIN_PERIOD, the module SHALL compute diff = hi_cnt - lo_cnt, signed NUM_BITS+2 bits, and register it into data on the next cycle.
REQ-015 If hi_cnt+lo_cnt < MIN_PERIOD on that edge, the module SHALL emit no sample and restart measurement from that edge (glitch rejection).
REQ-016 The data format SHALL be:
- data[RANGE_H:RANGE_H-NUM_BITS-1] = diff.
- Bits above RANGE_H are the sign extension of diff.
- Bits below the field are 0.
REQ-017 TIMEOUT SHALL equal 2^(NUM_BITS+1)-1 cycles. It is measured as hi_cnt+lo_cnt in HIGH or LOW, and by a separate idle counter in IDLE.
REQ-018 On timeout, the module SHALL emit a saturated sample: diff = +(2^(NUM_BITS+1)-1) if the synchronized level is 1, otherwise -(2^(NUM_BITS+1)-1). It SHALL then set timeout=1 and enter or stay in IDLE.
REQ-019 While in IDLE with no edge, the module SHALL repeat a saturated sample every TIMEOUT cycles.
REQ-020 timeout SHALL deassert on the first rising edge.
REQ-021 data_ready SHALL go high in the same cycle data updates and SHALL stay high for exactly 4 clk_pwm cycles, so slow consumer domains can sample it.
REQ-022 data SHALL remain stable from one update to the next.
REQ-023 If a new sample arrives while data_ready is high (only possible with MIN_PERIOD < 4), data SHALL update and the 4-cycle stretch SHALL restart.
REQ-024 Latency SHALL be: a pwm_in rise ending a period at input cycle t yields a data update and data_ready rise at cycle t+4.
REQ-025 The first partial period after reset or after IDLE SHALL NOT produce a sample.

Reset
REQ-026 Asynchronous assertion of nreset SHALL force the following reset values:
- Synchronizer and history flops = 0.
- FSM = IDLE.
- All counters = 0.
- data = 0.
- data_ready = 0.
- timeout = 0.
REQ-027 A reset asserted mid-period SHALL discard the partial measurement, with no sample emitted after release until a full period is seen.
REQ-028 Reset release SHALL be used synchronously. No output SHALL glitch on the release edge.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the default NUM_BITS and RANGE_H, and the helper widths NUM_BITS+2 and TIMEOUT.
REQ-030 The synchronizer plus edge detector SHALL be one sub-module, edge_sync, with outputs level, rise and fall. The rest SHALL be flat.

Verification
REQ-031 The bench SHALL cover these directed scenarios (defaults NUM_BITS=11, RANGE_H=28):
- Square wave, 300 cycles high and 100 low, repeated: after the 2nd rising edge, data = 200*2^16 = 13107200 and data_ready is high for 4 cycles, 4 cycles after the input rise.
- 100 high / 300 low: data = -13107200, i.e. 48-bit two's complement 0xFFFF_FF38_0000.
- 50% duty at 1024/1024: data = 0, data_ready strobes once per 2048 cycles, timeout stays 0.
- pwm_in held at 1 after reset: no sample before 4095 cycles, then data = 4095*2^16 with timeout=1, repeating every 4095 cycles. Held at 0 gives -4095*2^16.
- 5-cycle glitch pulse inside a LOW phase: no sample on the glitch's rising edge, and no data_ready. The next valid period is measured from the glitch edge.
- nreset pulsed while in HIGH: all outputs read 0, and the next sample appears only after one full subsequent period.
